cost_rom_arbiter: RTL and testbench
===================================

Name: cost_rom_arbiter

Overview:
- Shares the single external cost-ROM lookup port (W, J -> Cost) between NREQ job-assignment search engines.
- Round-robin arbitration with optional burst lock, so an engine can fetch all 8 costs of one permutation back-to-back.
- Routes each returned Cost back to the engine that issued the lookup, using a fixed-latency tag pipeline.
- Sits between the search engines and the testbench/ROM cost port.

Parameters:
NREQ, 4, number of requesters (2..8)
ROM_LAT, 1, cycles from W/J change to matching Cost on the Cost input (0..3)
MAX_LOCK, 8, max consecutive grants to one locked requester before forced release (1..15)

Ports:
CLK  in  1  clock
RST  in  1  reset
req  in  NREQ  lookup request per requester; held with operands stable until granted
req_w  in  3*NREQ  worker index per requester (slice i = bits 3i+2:3i)
req_j  in  3*NREQ  job index per requester
lock  in  NREQ  with an accepted request: keep grant for the next lookup
gnt  out  NREQ  one-hot combinational accept, same cycle as acceptance
W  out  3  registered worker index to cost ROM
J  out  3  registered job index to cost ROM
Cost  in  7  cost from ROM, valid ROM_LAT cycles after W/J
rsp_valid  out  NREQ  one-hot registered response strobe, 1 cycle
rsp_cost  out  7  registered returned cost, shared by all requesters
busy  out  1  high while any lookup is in flight
stat_cnt  out  16*NREQ  per-requester grant counters (optional feature)

Behaviour:
- Reset: RST asynchronous, active-high; clock CLK.
- Reset values: W=0, J=0, rsp_valid=0, rsp_cost=0, busy=0, stat_cnt=0. gnt=0 while RST is high.
- Reset also sets state=ARB, priority pointer=0, lock count=0, and clears the tag pipeline.
- States:
  - ARB: winner is the first requester with req=1, scanning from the pointer upward with wrap-around.
  - LOCKED: only the lock owner may be granted. req from all others is ignored and gnt stays 0 for them.
- Acceptance in cycle c:
  - gnt[winner]=1 in cycle c.
  - At the end of c: W<=req_w slice, J<=req_j slice; push {valid=1, id=winner} into the tag pipe.
- Cycles with no acceptance: W/J hold their value; push valid=0 into the tag pipe.
- Tag pipeline depth is ROM_LAT+1. When its head is valid, the engine registers rsp_cost<=Cost and rsp_valid[id]<=1, with no gap.
- Response timing: rsp_valid is high in cycle c+2+ROM_LAT (cycle c+3 at default).
- rsp_cost holds its last value when no response is issued.
- Throughput: one lookup per cycle. Back-to-back grants, to the same or different requesters, return responses in grant order.
- Transitions:
  - ARB -> LOCKED: accepted request with lock=1. Owner=winner, lock count=1. Pointer not updated.
  - ARB, accept with lock=0: pointer=(winner+1) mod NREQ.
  - LOCKED, owner accepted with lock=1: lock count += 1.
  - LOCKED -> ARB, normal release: owner accepted with lock=0. Pointer=(owner+1) mod NREQ.
  - LOCKED -> ARB, idle release: owner has req=0 for 1 cycle. Pointer=(owner+1) mod NREQ.
  - LOCKED -> ARB, forced release: accepted grant brings lock count to MAX_LOCK, regardless of lock. Pointer=(owner+1) mod NREQ.
- Boundaries:
  - No req in any cycle: gnt=0, no transition.
  - A requester whose req is not accepted must keep its operands stable.
  - Request arriving while its own response is in flight: legal.
- busy = any valid entry in the tag pipe or any rsp_valid bit set.
- Reset mid-operation drops all in-flight responses; no rsp_valid is issued after RST deasserts until a new acceptance.

Optional Feature:
- COST_ARB_STATS_EN defined:
  - stat_cnt slice i counts acceptances for requester i.
  - 16-bit, saturating at 65535.
  - Cleared by RST.
- COST_ARB_STATS_EN not defined: stat_cnt tied to 0, no counter logic.

Test Plan:
- Single requester: req[2]=1, w=5, j=3 in cycle 0 -> gnt=4'b0100 in cycle 0; W=5, J=3 in cycle 1; ROM returns 42; rsp_valid=4'b0100, rsp_cost=42 in cycle 3 (ROM_LAT=1).
- All four req held constantly, lock=0 -> grants 0,1,2,3,0,... one per cycle; rsp_valid follows the same order 3 cycles later.
- Requester 1 with lock=1 for 7 lookups then lock=0, others requesting -> 8 consecutive grants to 1, then next grant to 2.
- Requester 0 with lock=1 forever, MAX_LOCK=8 -> exactly 8 grants to 0, then grant to 1; 0 regains only after its round-robin turn.
- RST pulsed one cycle after two acceptances -> no rsp_valid afterwards, W=J=0, busy=0, next grant goes to the lowest-index requester.
- With COST_ARB_STATS_EN: 70000 grants to requester 3 -> stat_cnt slice 3 = 65535; the other slices count correctly.

Source files
------------

// File: rtl/cost_rom_arbiter.sv
// Round-robin arbiter sharing one cost-ROM lookup port between NREQ search engines,
// with burst lock and fixed-latency response routing. Optional COST_ARB_STATS_EN adds grant counters.
module cost_rom_arbiter #(
    parameter int NREQ     = 4,
    parameter int ROM_LAT  = 1,
    parameter int MAX_LOCK = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NREQ-1:0]      req,
    input  logic [3*NREQ-1:0]    req_w,
    input  logic [3*NREQ-1:0]    req_j,
    input  logic [NREQ-1:0]      lock,
    output logic [NREQ-1:0]      gnt,
    output logic [2:0]           W,
    output logic [2:0]           J,
    input  logic [6:0]           Cost,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [6:0]           rsp_cost,
    output logic                 busy,
    output logic [16*NREQ-1:0]   stat_cnt
);

    localparam int IDW   = $clog2(NREQ);
    localparam int DEPTH = ROM_LAT + 1;

    typedef enum logic {ARB, LOCKED} state_t;

    state_t           state;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   owner;
    logic [3:0]       lock_cnt;
    logic [IDW-1:0]   winner;
    logic [IDW-1:0]   cand;
    logic             found;
    logic             accept;

    logic [DEPTH-1:0] tag_vld_p;
    logic [IDW-1:0]   tag_id_p [DEPTH];

    function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] x);
        return (int'(x) == NREQ - 1) ? '0 : x + 1'b1;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDW'((int'(ptr) + k) % NREQ);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
        // While locked only the owner competes; everyone else is masked.
        if (state == LOCKED) begin
            found  = req[owner];
            winner = owner;
        end
        accept = found && !RST;
        gnt    = '0;
        if (accept) gnt[winner] = 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= ARB;
            ptr      <= '0;
            owner    <= '0;
            lock_cnt <= '0;
        end else begin
            case (state)
                ARB: begin
                    if (accept) begin
                        if (lock[winner] && MAX_LOCK > 1) begin
                            state    <= LOCKED;
                            owner    <= winner;
                            lock_cnt <= 4'd1;
                        end else begin
                            ptr <= next_id(winner);
                        end
                    end
                end
                LOCKED: begin
                    if (!req[owner]) begin
                        state    <= ARB;
                        ptr      <= next_id(owner);
                        lock_cnt <= '0;
                    end else if (lock[owner] && ({1'b0, lock_cnt} + 5'd1) < 5'(MAX_LOCK)) begin
                        lock_cnt <= lock_cnt + 4'd1;
                    end else begin
                        state    <= ARB;
                        ptr      <= next_id(owner);
                        lock_cnt <= '0;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

    // Stage p0: operand register to ROM and tag push; head of tag pipe lines up with Cost.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            W         <= '0;
            J         <= '0;
            tag_vld_p <= '0;
            for (int k = 0; k < DEPTH; k++) tag_id_p[k] <= '0;
            rsp_valid <= '0;
            rsp_cost  <= '0;
        end else begin
            if (accept) begin
                W <= req_w[int'(winner)*3 +: 3];
                J <= req_j[int'(winner)*3 +: 3];
            end
            tag_vld_p[0] <= accept;
            tag_id_p[0]  <= winner;
            for (int k = 1; k < DEPTH; k++) begin
                tag_vld_p[k] <= tag_vld_p[k-1];
                tag_id_p[k]  <= tag_id_p[k-1];
            end
            rsp_valid <= '0;
            if (tag_vld_p[DEPTH-1]) begin
                rsp_valid[tag_id_p[DEPTH-1]] <= 1'b1;
                rsp_cost                     <= Cost;
            end
        end
    end

    assign busy = (|tag_vld_p) | (|rsp_valid);

`ifdef COST_ARB_STATS_EN
    logic [15:0] cnt [NREQ];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < NREQ; k++) cnt[k] <= '0;
        end else if (accept) begin
            cnt[winner] <= sat_inc(cnt[winner]);
        end
    end

    always_comb begin
        stat_cnt = '0;
        for (int k = 0; k < NREQ; k++) stat_cnt[16*k +: 16] = cnt[k];
    end
`else
    assign stat_cnt = '0;
`endif

endmodule

// File: tb/tb_cost_rom_arbiter.sv
// Randomized bench for cost_rom_arbiter against a transaction-level reference model.
module tb_cost_rom_arbiter;

    localparam int NREQ     = 4;
    localparam int ROM_LAT  = 1;
    localparam int MAX_LOCK = 8;

    logic                CLK = 1'b0;
    logic                RST;
    logic [NREQ-1:0]     req;
    logic [3*NREQ-1:0]   req_w;
    logic [3*NREQ-1:0]   req_j;
    logic [NREQ-1:0]     lock;
    logic [NREQ-1:0]     gnt;
    logic [2:0]          W;
    logic [2:0]          J;
    logic [6:0]          Cost;
    logic [NREQ-1:0]     rsp_valid;
    logic [6:0]          rsp_cost;
    logic                busy;
    logic [16*NREQ-1:0]  stat_cnt;

    cost_rom_arbiter #(.NREQ(NREQ), .ROM_LAT(ROM_LAT), .MAX_LOCK(MAX_LOCK)) dut (
        .CLK(CLK), .RST(RST), .req(req), .req_w(req_w), .req_j(req_j), .lock(lock),
        .gnt(gnt), .W(W), .J(J), .Cost(Cost), .rsp_valid(rsp_valid),
        .rsp_cost(rsp_cost), .busy(busy), .stat_cnt(stat_cnt)
    );

    always #5 CLK = ~CLK;

    // One-cycle ROM: Cost reflects the W/J presented during the previous cycle.
    logic [6:0] rom [64];
    always @(posedge CLK) Cost <= rom[{W, J}];

    typedef struct {
        int         due;
        int         id;
        logic [6:0] cost;
    } rsp_t;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    rsp_t       q[$];
    bit         pend [NREQ];
    logic [2:0] pw [NREQ];
    logic [2:0] pj [NREQ];
    bit         pl [NREQ];
    bit         m_locked;
    int         m_owner, m_ptr, m_cnt;
    logic [2:0] exp_w, exp_j;
    logic [6:0] exp_cost;
    int         stat_m [NREQ];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_locked = 0;
        m_owner  = 0;
        m_ptr    = 0;
        m_cnt    = 0;
        exp_w    = '0;
        exp_j    = '0;
        exp_cost = '0;
        for (int i = 0; i < NREQ; i++) stat_m[i] = 0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_W", 32'(W), 0);
        chk("rst_J", 32'(J), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_cost", 32'(rsp_cost), 0);
        chk("rst_busy", 32'(busy), 0);
        for (int i = 0; i < NREQ; i++) chk("rst_stat", 32'(stat_cnt[16*i +: 16]), 0);
        model_reset();
        cyc++;
    endtask

    task automatic step(input int req_pct, input int lock_pct);
        int win;
        int r;
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!pend[i] && $urandom_range(99) < req_pct) begin
                pend[i] = 1;
                pw[i]   = 3'($urandom_range(7));
                pj[i]   = 3'($urandom_range(7));
                pl[i]   = ($urandom_range(99) < lock_pct);
            end
            req[i]          = pend[i];
            lock[i]         = pl[i];
            req_w[3*i +: 3] = pw[i];
            req_j[3*i +: 3] = pj[i];
        end
        #1;
        win = -1;
        if (m_locked) begin
            if (pend[m_owner]) win = m_owner;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                r = (m_ptr + k) % NREQ;
                if (win < 0 && pend[r]) win = r;
            end
        end
        chk("gnt", 32'(gnt), (win < 0) ? 0 : (1 << win));
        chk("busy", 32'(busy), (q.size() > 0) ? 1 : 0);
        if (q.size() > 0 && q[0].due == cyc) begin
            chk("rsp_valid", 32'(rsp_valid), 1 << q[0].id);
            chk("rsp_cost", 32'(rsp_cost), 32'(q[0].cost));
            exp_cost = q[0].cost;
            void'(q.pop_front());
        end else begin
            chk("rsp_valid_idle", 32'(rsp_valid), 0);
            chk("rsp_cost_hold", 32'(rsp_cost), 32'(exp_cost));
        end
        chk("W", 32'(W), 32'(exp_w));
        chk("J", 32'(J), 32'(exp_j));

        if (win >= 0) begin
            q.push_back('{cyc + 2 + ROM_LAT, win, rom[{pw[win], pj[win]}]});
            exp_w = pw[win];
            exp_j = pj[win];
            if (stat_m[win] < 65535) stat_m[win]++;
            pend[win] = 0;
            if (!m_locked) begin
                if (pl[win] && MAX_LOCK > 1) begin
                    m_locked = 1;
                    m_owner  = win;
                    m_cnt    = 1;
                end else begin
                    m_ptr = (win + 1) % NREQ;
                end
            end else begin
                m_cnt++;
                if (!pl[win] || m_cnt >= MAX_LOCK) begin
                    m_locked = 0;
                    m_ptr    = (m_owner + 1) % NREQ;
                end
            end
        end else if (m_locked) begin
            m_locked = 0;
            m_ptr    = (m_owner + 1) % NREQ;
        end
        cyc++;
    endtask

    initial begin
        RST   = 1'b1;
        req   = '0;
        req_w = '0;
        req_j = '0;
        lock  = '0;
        for (int i = 0; i < 64; i++) rom[i] = 7'($urandom_range(127));
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 0;
            pw[i]   = '0;
            pj[i]   = '0;
            pl[i]   = 0;
        end
        model_reset();
        do_reset();

        for (int n = 0; n < 300; n++) step(40, 20);
        for (int n = 0; n < 300; n++) step(100, 0);
        for (int n = 0; n < 300; n++) step(90, 85);
        step(100, 0);
        step(100, 0);
        do_reset();
        for (int n = 0; n < 200; n++) step(25, 50);
        for (int n = 0; n < 300; n++) step(100, 100);
        do_reset();
        for (int n = 0; n < 200; n++) step(70, 40);
        for (int n = 0; n < 6; n++) step(0, 0);

        for (int i = 0; i < NREQ; i++) begin
`ifdef COST_ARB_STATS_EN
            chk("stat_cnt", 32'(stat_cnt[16*i +: 16]), 32'(stat_m[i]));
`else
            chk("stat_cnt_off", 32'(stat_cnt[16*i +: 16]), 0);
`endif
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
